lut_stream_loader: RTL and testbench

//   Upstream feeder for the serial-load LUT. Accepts table words over a valid/ready

---
 rtl/lut_stream_loader.sv | 168 ++++++++++++++++
 tb/tb_lut_stream_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_stream_loader.sv
// Streams table words MSB-first into a serial-load LUT over sd/cs_n.
// Build option LUT_LOADER_CRC_EN adds a CRC-8 (0x07) of the bits sent.
module lut_stream_loader #(
    parameter  int WORD_W     = 4,
    parameter  int TOTAL_BITS = 256,
    localparam int NUM_WORDS  = TOTAL_BITS / WORD_W,
    localparam int CNT_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sd,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt
`ifdef LUT_LOADER_CRC_EN
    ,
    output logic [7:0]        crc
`endif
);

    localparam int BL_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              sd_q, sd_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              shift_en;
    logic              clr_crc;
    logic              accept;

    assign in_ready = (state_q == LOAD) && (bits_left_q == '0)
                   && (word_cnt_q < CNT_W'(NUM_WORDS)) && !abort;
    assign accept   = in_valid && in_ready;

    assign sd       = sd_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            word_cnt_q  <= '0;
            sd_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            word_cnt_q  <= word_cnt_d;
            sd_q        <= sd_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state: abort wins over shifting, accepting and completing
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        word_cnt_d  = word_cnt_q;
        sd_d        = sd_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        shift_en    = 1'b0;
        clr_crc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                if (start) begin
                    state_d     = LOAD;
                    busy_d      = 1'b1;
                    word_cnt_d  = '0;
                    bits_left_d = '0;
                    clr_crc     = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (bits_left_q != '0) begin
                    sd_d        = shreg_q[WORD_W-1];
                    shreg_d     = shreg_q << 1;
                    cs_n_d      = 1'b0;
                    bits_left_d = bits_left_q - BL_W'(1);
                    shift_en    = 1'b1;
                end else if (accept) begin
                    sd_d        = in_data[WORD_W-1];
                    shreg_d     = in_data << 1;
                    cs_n_d      = 1'b0;
                    bits_left_d = BL_W'(WORD_W - 1);
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    shift_en    = 1'b1;
                end else if (word_cnt_q == CNT_W'(NUM_WORDS)) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cs_n_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LUT_LOADER_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                             input logic       b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign crc = crc_q;

    // CRC follows every bit presented on sd
    always_comb begin
        crc_d = crc_q;
        if (clr_crc) begin
            crc_d = 8'h00;
        end else if (shift_en) begin
            crc_d = crc8_step(crc_q, sd_d);
        end
    end

    // CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    logic unused_crc;
    assign unused_crc = shift_en ^ clr_crc;
`endif

endmodule

// File: tb/tb_lut_stream_loader.sv
// Directed bench for lut_stream_loader with a behavioural LUT shift model.
// Build option LUT_LOADER_CRC_EN enables the CRC checks.
module tb_lut_stream_loader;

    localparam int NW = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       sd;
    logic       cs_n;
    logic       busy;
    logic       done;
    logic [6:0] word_cnt;
`ifdef LUT_LOADER_CRC_EN
    logic [7:0] crc;
`endif

    int checks = 0;
    int failures = 0;

    logic [3:0]   words [NW];
    logic [255:0] lut_m = '0;
    int           shifts = 0;

    always #5 clk = ~clk;

    lut_stream_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sd       (sd),
        .cs_n     (cs_n),
        .busy     (busy),
        .done     (done),
`ifdef LUT_LOADER_CRC_EN
        .crc      (crc),
`endif
        .word_cnt (word_cnt)
    );

    // Behavioural serial-load LUT: shifts sd in whenever cs_n is low
    always @(posedge clk) begin
        if (!cs_n) begin
            lut_m  <= {lut_m[254:0], sd};
            shifts <= shifts + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_model();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int w = 0; w < NW; w++) begin
            for (int b = 3; b >= 0; b--) begin
                fb = c[7] ^ words[w][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic chk_table(input string tag, input logic inv);
        logic [3:0] e4;
        int bad;
        bad = 0;
        for (int e = 0; e < NW; e++) begin
            e4 = e[3:0];
            if (inv) e4 = ~e4;
            if (lut_m[e*4 +: 4] !== e4) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
        chk({tag, "_e0"}, 64'(lut_m[3:0]), inv ? 64'hf : 64'h0);
        chk({tag, "_e63"}, 64'(lut_m[255:252]), inv ? 64'h0 : 64'hf);
    endtask

    // Called at a negedge; runs one load and returns at done, idle or reset
    task automatic run_load(input int gap_len, input int abort_at,
                            input int rst_at, input int start_at,
                            output int done_n, output int first,
                            output int last, output int lows);
        int idx;
        int gap_left;
        int n;
        logic acc;
        logic in_gap;
        idx = 0;
        gap_left = gap_len;
        done_n = -1;
        first = -1;
        last = -1;
        lows = 0;
        n = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (n < 400) begin
            if (n == 0) begin
                chk("busy_after_start", 64'(busy), 64'd1);
                chk("done_low_at_start", 64'(done), 64'd0);
            end
            if (!cs_n) begin
                lows++;
                if (first < 0) first = n;
                last = n;
            end
            if (done) begin
                done_n = n;
                break;
            end
            if (!busy) break;
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_cs_n", 64'(cs_n), 64'd1);
                chk("rst_sd", 64'(sd), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_word_cnt", 64'(word_cnt), 64'd0);
                break;
            end
            start = (n == start_at);
            abort = (abort_at >= 0) && (int'(word_cnt) == abort_at);
            in_gap = (idx == 6) && (gap_left > 0);
            in_data = words[idx < NW ? idx : 0];
            in_valid = (idx < NW) && !in_gap;
            #1;
            if (in_gap && in_ready) gap_left--;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    int dn, fl, ll, lw;
    int sh0;
    logic seen_done;

    initial begin
        for (int i = 0; i < NW; i++) words[i] = 4'(63 - i);
        @(negedge clk);
        chk("init_cs_n", 64'(cs_n), 64'd1);
        chk("init_sd", 64'(sd), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd0);
        chk("init_word_cnt", 64'(word_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Continuous load, entry value = entry index
        run_load(0, -1, -1, -1, dn, fl, ll, lw);
        chk("t2_done_cycle", 64'(dn), 64'd257);
        chk("t2_first_low", 64'(fl), 64'd1);
        chk("t2_last_low", 64'(ll), 64'd256);
        chk("t2_low_count", 64'(lw), 64'd256);
        chk("t2_cs_n_at_done", 64'(cs_n), 64'd1);
        chk("t2_word_cnt", 64'(word_cnt), 64'd64);
        chk_table("t2_table", 1'b0);

        // Back-to-back with the inverse table, start right after done
        for (int i = 0; i < NW; i++) words[i] = ~4'(63 - i);
        run_load(0, -1, -1, -1, dn, fl, ll, lw);
        chk("t5_done_cycle", 64'(dn), 64'd257);
        chk_table("t5_table", 1'b1);

        // Three-cycle valid gap after word 5
        for (int i = 0; i < NW; i++) words[i] = 4'(63 - i);
        @(negedge clk);
        chk("idle_done_clear", 64'(done), 64'd0);
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        run_load(3, -1, -1, -1, dn, fl, ll, lw);
        chk("t3_done_cycle", 64'(dn), 64'd260);
        chk("t3_low_count", 64'(lw), 64'd256);
        chk("t3_span", 64'(ll - fl + 1), 64'd259);
        chk_table("t3_table", 1'b0);

        // Abort at word_cnt=10, with a stray start during LOAD
        @(negedge clk);
        run_load(0, 10, -1, 20, dn, fl, ll, lw);
        chk("t4_cs_n", 64'(cs_n), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_word_cnt", 64'(word_cnt), 64'd10);
        chk("t4_no_done", 64'(dn), 64'hffff_ffff_ffff_ffff);
        seen_done = 1'b0;
        sh0 = shifts;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("t4_done_never", 64'(seen_done), 64'd0);
        chk("t4_lut_idle", 64'(shifts - sh0), 64'd0);
        chk("t4_word_cnt_hold", 64'(word_cnt), 64'd10);

        // Asynchronous reset mid-run freezes the LUT
        run_load(0, -1, 100, -1, dn, fl, ll, lw);
        sh0 = shifts;
        repeat (5) @(negedge clk);
        chk("t1_lut_frozen", 64'(shifts - sh0), 64'd0);
        chk("t1_cs_n_hold", 64'(cs_n), 64'd1);
        rst = 1'b0;
        @(negedge clk);

`ifdef LUT_LOADER_CRC_EN
        for (int i = 0; i < NW; i++) words[i] = 4'h0;
        run_load(0, -1, -1, -1, dn, fl, ll, lw);
        chk("t6_zero_done", 64'(dn), 64'd257);
        chk("t6_zero_crc", 64'(crc), 64'h00);
        @(negedge clk);
`endif
        // Random table after reset recovery
        for (int i = 0; i < NW; i++) words[i] = 4'($urandom_range(0, 15));
        run_load(0, -1, -1, -1, dn, fl, ll, lw);
        chk("rand_done_cycle", 64'(dn), 64'd257);
        begin
            int bad;
            bad = 0;
            for (int e = 0; e < NW; e++)
                if (lut_m[e*4 +: 4] !== words[NW-1-e]) bad++;
            chk("rand_table", 64'(bad), 64'd0);
        end
`ifdef LUT_LOADER_CRC_EN
        chk("t6_rand_crc", 64'(crc), 64'(crc_model()));
        repeat (3) @(negedge clk);
        chk("t6_crc_stable", 64'(crc), 64'(crc_model()));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
